// File: rtl/lsu_pkg.sv
// lsu_pkg: shared funct3 codes, byte masks, FSM states and beat helpers for the load-store controller
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] BM_WORD = 4'b1111;
    localparam logic [3:0] BM_HALF = 4'b0011;
    localparam logic [3:0] BM_BYTE = 4'b0001;
    localparam logic [3:0] BM_NONE = 4'b0000;

    typedef enum logic [1:0] {IDLE, ACCESS, ERR, RESP} state_t;

    // access size in bytes minus one, which doubles as the alignment mask
    function automatic logic [1:0] size_f(input logic [2:0] funct3);
        return funct3[1:0] == 2'b10 ? 2'd3 : funct3[1:0] == 2'b01 ? 2'd1 : 2'd0;
    endfunction

    function automatic logic [2:0] beats_f(input logic [2:0] funct3, input logic [1:0] addr);
        return (addr & size_f(funct3)) != 2'd0 ? 3'(size_f(funct3)) + 3'd1 : 3'd1;
    endfunction

    function automatic logic [3:0] bmask_f(input logic [2:0] funct3);
        return size_f(funct3) == 2'd3 ? BM_WORD : size_f(funct3) == 2'd1 ? BM_HALF : BM_BYTE;
    endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// lsu_load_ext: sign/zero extension of assembled load data by funct3
module lsu_load_ext
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] data,
    output logic [31:0] result
);

    assign result = funct3 == F3_B  ? {{24{data[7]}}, data[7:0]} :
                    funct3 == F3_BU ? {24'b0, data[7:0]} :
                    funct3 == F3_H  ? {{16{data[15]}}, data[15:0]} :
                    funct3 == F3_HU ? {16'b0, data[15:0]} : data;

endmodule

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: RV32 load/store initiator for a byte-masked memory, splitting misaligned accesses into byte beats
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W           = 11,
    parameter int DATA_W           = 32,
    parameter int SPLIT_MISALIGNED = 1
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_we,
    input  logic [2:0]        i_req_funct3,
    input  logic [31:0]       i_req_addr,
    input  logic [DATA_W-1:0] i_req_wdata,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [DATA_W-1:0] o_rsp_rdata,
    output logic              o_rsp_err,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic [3:0]        o_mem_bmask,
    output logic              o_mem_wren,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    state_t state, state_n;
    logic we_q, err_q, idle, accept, f3_ok, legal, last_beat, go, b_we;
    logic [2:0] f3_q, n_q, b_f3, b_n;
    logic [1:0] k_q, b_k;
    logic [ADDR_W-1:0] addr_q, b_addr;
    logic [ADDR_W:0] last_addr;
    logic [DATA_W-1:0] wdata_q, b_wdata, acc_q, ext;

    assign idle      = state == IDLE;
    assign accept    = i_req_valid && idle;
    assign f3_ok     = i_req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU} && !(i_req_we && i_req_funct3[2]);
    assign last_addr = {1'b0, i_req_addr[ADDR_W-1:0]} + (ADDR_W+1)'(size_f(i_req_funct3));
    assign legal     = f3_ok && i_req_addr[31:ADDR_W] == '0 && !last_addr[ADDR_W] &&
                       (SPLIT_MISALIGNED != 0 || beats_f(i_req_funct3, i_req_addr[1:0]) == 3'd1);
    assign last_beat = 3'(k_q) + 3'd1 == n_q;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = accept ? (legal ? ACCESS : ERR) : IDLE;
            ACCESS:  state_n = last_beat ? RESP : ACCESS;
            ERR:     state_n = RESP;
            RESP:    state_n = i_rsp_ready ? IDLE : RESP;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) state <= IDLE;
        else            state <= state_n;
    end

    // the next beat comes from the live request on accept, else from the latched one
    assign b_we    = idle ? i_req_we : we_q;
    assign b_f3    = idle ? i_req_funct3 : f3_q;
    assign b_addr  = idle ? i_req_addr[ADDR_W-1:0] : addr_q;
    assign b_wdata = idle ? i_req_wdata : wdata_q;
    assign b_n     = idle ? beats_f(i_req_funct3, i_req_addr[1:0]) : n_q;
    assign b_k     = idle ? 2'd0 : k_q + 2'd1;
    assign go      = idle ? accept && legal : state == ACCESS && !last_beat;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            f3_q        <= '0;
            n_q         <= '0;
            k_q         <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            acc_q       <= '0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            o_mem_bmask <= BM_NONE;
            o_mem_wren  <= 1'b0;
        end else begin
            if (accept) begin
                we_q    <= i_req_we;
                err_q   <= !legal;
                f3_q    <= i_req_funct3;
                n_q     <= beats_f(i_req_funct3, i_req_addr[1:0]);
                k_q     <= '0;
                addr_q  <= i_req_addr[ADDR_W-1:0];
                wdata_q <= i_req_wdata;
                acc_q   <= '0;
            end
            if (state == ACCESS) begin
                k_q <= k_q + 2'd1;
                if (!we_q && n_q != 3'd1) acc_q[8*k_q +: 8] <= i_mem_rdata[7:0];
                else if (!we_q)           acc_q <= i_mem_rdata;
            end
            o_mem_addr  <= go ? b_addr + ADDR_W'(b_k) : '0;
            o_mem_bmask <= go ? (b_n != 3'd1 ? BM_BYTE : bmask_f(b_f3)) : BM_NONE;
            o_mem_wdata <= go ? (b_n != 3'd1 ? DATA_W'(b_wdata[8*b_k +: 8]) : b_wdata) : '0;
            o_mem_wren  <= go && b_we;
        end
    end

    lsu_load_ext u_ext (
        .funct3 (f3_q),
        .data   (acc_q),
        .result (ext)
    );

    assign o_req_ready = idle;
    assign o_rsp_valid = state == RESP;
    assign o_rsp_err   = state == RESP && err_q;
    assign o_rsp_rdata = state == RESP && !err_q && !we_q ? ext : '0;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: randomized and directed checks of lsu_mem_ctrl against a request-level model
module tb_lsu_mem_ctrl;

    typedef struct {
        logic [10:0] a;
        logic [3:0]  m;
        logic        w;
        logic [31:0] d;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0, req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
    logic [2:0]  req_f3 = '0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, rsp_valid, rsp_err, m_wren;
    logic [31:0] rsp_rdata, m_wdata, m_rdata;
    logic [10:0] m_addr;
    logic [3:0]  m_bmask;

    logic        valid0 = 1'b0, rsp_ready0 = 1'b0;
    logic        req_ready0, rsp_valid0, rsp_err0, m_wren0, act0 = 1'b0;
    logic [31:0] rsp_rdata0, m_wdata0;
    logic [10:0] m_addr0;
    logic [3:0]  m_bmask0;

    logic [7:0]  mem [2048];
    logic [7:0]  ref_mem [2048];
    logic [2:0]  legal_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    beat_t       exp_q [$];
    beat_t       cb;
    int          n_chk = 0, n_pass = 0, wren_cnt = 0, lat;
    logic [31:0] rd, bm32;
    logic        er;

    lsu_mem_ctrl dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_we(req_we), .i_req_funct3(req_f3), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err),
        .o_mem_addr(m_addr), .o_mem_wdata(m_wdata), .o_mem_bmask(m_bmask), .o_mem_wren(m_wren),
        .i_mem_rdata(m_rdata)
    );

    lsu_mem_ctrl #(.SPLIT_MISALIGNED(0)) dut0 (
        .i_clk(clk), .i_reset_n(rst_n), .i_req_valid(valid0), .o_req_ready(req_ready0),
        .i_req_we(req_we), .i_req_funct3(req_f3), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
        .o_rsp_valid(rsp_valid0), .i_rsp_ready(rsp_ready0), .o_rsp_rdata(rsp_rdata0), .o_rsp_err(rsp_err0),
        .o_mem_addr(m_addr0), .o_mem_wdata(m_wdata0), .o_mem_bmask(m_bmask0), .o_mem_wren(m_wren0),
        .i_mem_rdata(m_rdata)
    );

    // memory returns the bytes starting at the addressed byte, already right-aligned
    assign m_rdata = {mem[m_addr + 11'd3], mem[m_addr + 11'd2], mem[m_addr + 11'd1], mem[m_addr]};

    always @(posedge clk) begin
        if (m_wren) begin
            wren_cnt++;
            for (int i = 0; i < 4; i++)
                if (m_bmask[i]) mem[m_addr + 11'(i)] <= m_wdata[8*i +: 8];
        end
        if (m_wren0 || m_bmask0 != 4'd0) act0 <= 1'b1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    always @(negedge clk) begin
        if (rst_n && (m_wren || m_bmask != 4'd0)) begin
            if (exp_q.size() == 0) chk("beat_unexpected", 32'({m_wren, m_bmask}), 32'd0);
            else begin
                cb = exp_q.pop_front();
                bm32 = {{8{cb.m[3]}}, {8{cb.m[2]}}, {8{cb.m[1]}}, {8{cb.m[0]}}};
                chk("beat_addr", 32'(m_addr), 32'(cb.a));
                chk("beat_bmask", 32'(m_bmask), 32'(cb.m));
                chk("beat_wren", 32'(m_wren), 32'(cb.w));
                if (cb.w) chk("beat_wdata", m_wdata & bm32, cb.d & bm32);
            end
        end
        if (rst_n && rsp_valid) chk("ready_in_resp", 32'(req_ready), 32'd0);
    end

    task automatic req(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                       input int hold, output logic [31:0] r, output logic e_out, output int l);
        int size, n;
        bit f3ok, inr, mis, e;
        logic [31:0] v, r0;
        beat_t b;
        size = f3[1:0] == 2'd0 ? 1 : f3[1:0] == 2'd1 ? 2 : 4;
        f3ok = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) && !(we && f3[2]);
        inr  = {32'b0, addr} + 64'(size) <= 64'd2048;
        mis  = (addr % size) != 0;
        e    = !f3ok || !inr;
        n    = mis ? size : 1;
        v    = '0;
        if (!e) begin
            for (int i = 0; i < size; i++) v[8*i +: 8] = ref_mem[addr[10:0] + 11'(i)];
            if (!f3[2] && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8*size));
            if (we) begin
                v = '0;
                for (int i = 0; i < size; i++) ref_mem[addr[10:0] + 11'(i)] = wd[8*i +: 8];
            end
            for (int k = 0; k < n; k++) begin
                b.a = addr[10:0] + 11'(k);
                b.m = mis ? 4'b0001 : 4'((1 << size) - 1);
                b.w = we;
                b.d = mis ? {24'b0, wd[8*k +: 8]} : wd;
                exp_q.push_back(b);
            end
        end
        for (int t = 0; !req_ready; t++) begin
            if (t == 20) begin
                $display("FAIL ready_timeout: req_ready stuck at 0");
                $display("%0d/%0d checks passed", n_pass, n_chk + 1);
                $fatal(1);
            end
            @(posedge clk); #1;
        end
        req_we = we; req_f3 = f3; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
        wren_cnt = 0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        l = 1;
        while (!rsp_valid && l < 20) begin
            @(posedge clk); #1;
            l++;
        end
        r = rsp_rdata;
        e_out = rsp_err;
        chk("rsp_valid", 32'(rsp_valid), 32'd1);
        chk("latency", 32'(l), 32'(e ? 2 : n + 1));
        chk("rsp_err", 32'(e_out), 32'(e));
        chk("rsp_rdata", r, v);
        for (int h = 0; h < hold; h++) begin
            r0 = rsp_rdata;
            @(posedge clk); #1;
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_ready", 32'(req_ready), 32'd0);
            chk("hold_rdata", rsp_rdata, r0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("rsp_drop", 32'(rsp_valid), 32'd0);
        chk("ready_back", 32'(req_ready), 32'd1);
        chk("beats_left", 32'(exp_q.size()), 32'd0);
        chk("wren_count", 32'(wren_cnt), 32'((we && !e) ? n : 0));
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) begin
            mem[i] = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ready", 32'(req_ready), 32'd1);
        chk("reset_valid", 32'(rsp_valid), 32'd0);
        chk("reset_wren", 32'(m_wren), 32'd0);
        chk("reset_bmask", 32'(m_bmask), 32'd0);
        chk("reset_rdata", rsp_rdata, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        req(1'b1, 3'd2, 32'h010, 32'hDEADBEEF, 0, rd, er, lat);
        chk("sw_pulses", 32'(wren_cnt), 32'd1);
        req(1'b0, 3'd2, 32'h010, 32'h0, 0, rd, er, lat);
        chk("lw_lit", rd, 32'hDEADBEEF);
        chk("lw_lat", 32'(lat), 32'd2);
        chk("lw_err", 32'(er), 32'd0);
        req(1'b1, 3'd0, 32'h013, 32'h80, 0, rd, er, lat);
        req(1'b0, 3'd0, 32'h013, 32'h0, 1, rd, er, lat);
        chk("lb_lit", rd, 32'hFFFFFF80);
        req(1'b0, 3'd4, 32'h013, 32'h0, 0, rd, er, lat);
        chk("lbu_lit", rd, 32'h00000080);
        req(1'b1, 3'd1, 32'h006, 32'h8001, 0, rd, er, lat);
        req(1'b0, 3'd1, 32'h006, 32'h0, 0, rd, er, lat);
        chk("lh_lit", rd, 32'hFFFF8001);
        req(1'b0, 3'd5, 32'h006, 32'h0, 0, rd, er, lat);
        chk("lhu_lit", rd, 32'h00008001);
        req(1'b1, 3'd2, 32'h00D, 32'h11223344, 0, rd, er, lat);
        chk("split_pulses", 32'(wren_cnt), 32'd4);
        chk("split_mem", {mem[16], mem[15], mem[14], mem[13]}, 32'h11223344);
        req(1'b0, 3'd2, 32'h00D, 32'h0, 0, rd, er, lat);
        chk("split_lw_lit", rd, 32'h11223344);
        chk("split_lw_lat", 32'(lat), 32'd5);

        req(1'b0, 3'd2, 32'h800, 32'h0, 3, rd, er, lat);
        chk("oor_err", 32'(er), 32'd1);
        chk("oor_rdata", rd, 32'd0);
        req(1'b0, 3'd2, 32'h7FE, 32'h0, 0, rd, er, lat);
        chk("wrap_err", 32'(er), 32'd1);
        req(1'b1, 3'd3, 32'h020, 32'h55, 0, rd, er, lat);
        chk("f3_err", 32'(er), 32'd1);
        chk("f3_nowren", 32'(wren_cnt), 32'd0);
        req(1'b0, 3'd2, 32'h7FC, 32'h0, 0, rd, er, lat);
        chk("last_word_ok", 32'(er), 32'd0);

        req_we = 1'b1; req_f3 = 3'd2; req_addr = 32'h101; req_wdata = $urandom; req_valid = 1'b1;
        for (int k = 0; k < 4; k++) exp_q.push_back('{11'h101 + 11'(k), 4'b0001, 1'b1, {24'b0, req_wdata[8*k +: 8]}});
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("abort_wren", 32'(m_wren), 32'd0);
        chk("abort_bmask", 32'(m_bmask), 32'd0);
        chk("abort_valid", 32'(rsp_valid), 32'd0);
        chk("abort_ready", 32'(req_ready), 32'd1);
        rst_n = 1'b1;
        exp_q.delete();
        for (int i = 'h101; i <= 'h104; i++) ref_mem[i] = mem[i];
        act0 = 1'b0;
        @(posedge clk); #1;

        req_we = 1'b0; req_f3 = 3'd1; req_addr = 32'h001; valid0 = 1'b1;
        @(posedge clk); #1;
        valid0 = 1'b0;
        lat = 1;
        while (!rsp_valid0 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("nosplit_err", 32'(rsp_err0), 32'd1);
        chk("nosplit_lat", 32'(lat), 32'd2);
        chk("nosplit_rdata", rsp_rdata0, 32'd0);
        chk("nosplit_nomem", 32'(act0), 32'd0);
        rsp_ready0 = 1'b1;
        @(posedge clk); #1;
        rsp_ready0 = 1'b0;
        chk("nosplit_drop", 32'(rsp_valid0), 32'd0);
        req_f3 = 3'd2; req_addr = 32'h010; valid0 = 1'b1;
        @(posedge clk); #1;
        valid0 = 1'b0;
        @(posedge clk); #1;
        chk("nosplit_aligned_ok", 32'({rsp_valid0, rsp_err0}), 32'b10);
        rsp_ready0 = 1'b1;
        @(posedge clk); #1;
        rsp_ready0 = 1'b0;

        repeat (250) begin
            logic        w;
            logic [2:0]  f;
            logic [31:0] a;
            int          sel;
            w = 1'($urandom_range(0, 1));
            f = $urandom_range(0, 3) != 0 ? legal_f3[$urandom_range(0, 4)] : 3'($urandom_range(0, 7));
            sel = $urandom_range(0, 9);
            a = sel == 0 ? $urandom : sel == 1 ? 32'(2040 + $urandom_range(0, 10)) : 32'($urandom_range(0, 63));
            req(w, f, a, $urandom, $urandom_range(0, 2), rd, er, lat);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load-store controller that acts as the initiator toward the 2 KB byte-masked data memory. It sits between the execute stage and that memory.
- Accepts one RV32 load or store request per handshake. Drives the memory address, write data, byte mask and write enable, then returns sign- or zero-extended load data.
- Misaligned halfword and word accesses are split into sequential byte beats, because the memory cannot perform them natively. Out-of-range and illegal accesses are flagged as errors.

Parameters:
- ADDR_W, 11, memory byte-address width (2 KB).
- DATA_W, 32, data width; only 32 is supported.
- SPLIT_MISALIGNED, 1, 1 = split misaligned accesses into byte beats; 0 = report a misaligned access as an error with no memory access.

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset_n  in  1  synchronous, active-low reset.
- i_req_valid  in  1  request valid.
- o_req_ready  out  1  high only in IDLE.
- i_req_we  in  1  1 = store, 0 = load.
- i_req_funct3  in  3  RV32 funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- i_req_addr  in  32  byte address.
- i_req_wdata  in  32  store data, low-aligned.
- o_rsp_valid  out  1  response valid; held until accepted.
- i_rsp_ready  in  1  response accept.
- o_rsp_rdata  out  32  extended load data; 0 for stores and errors.
- o_rsp_err  out  1  range, funct3 or misalignment error.
- o_mem_addr  out  ADDR_W  memory byte address.
- o_mem_wdata  out  32  memory write data, low-aligned.
- o_mem_bmask  out  4  1111 word, 0011 half, 0001 byte, 0000 idle.
- o_mem_wren  out  1  memory write enable.
- i_mem_rdata  in  32  combinational memory read data, already right-shifted by offset×8 for half and byte accesses.

Behaviour:
- Reset: i_reset_n low at a rising edge forces state IDLE. All outputs go to 0 except o_req_ready, which goes to 1. Reset mid-operation abandons the request; store beats already written stay in memory.
- States: IDLE, ACCESS, ERR, RESP.
- IDLE → ACCESS on i_req_valid && o_req_ready when the request is legal. The request is latched and the beat count N is computed:
  - Aligned access: N = 1.
  - Misaligned halfword (addr[0] = 1): N = 2 byte beats.
  - Misaligned word (addr[1:0] != 0): N = 4 byte beats.
- IDLE → ERR when the request is illegal:
  - i_req_addr[31:ADDR_W] != 0.
  - funct3 is not in {000, 001, 010, 100, 101}, or is 1xx on a store.
  - The access is misaligned and SPLIT_MISALIGNED = 0.
- ACCESS: one beat per cycle, beat counter k = 0..N-1, with all memory outputs registered.
  - Aligned beat: bmask is 1111 / 0011 / 0001 per size; o_mem_addr = latched address.
  - Split beat: bmask = 0001, o_mem_addr = addr + k, o_mem_wdata[7:0] = wdata byte k.
  - Stores: o_mem_wren = 1 for exactly one cycle per beat.
  - Loads: o_mem_wren = 0; i_mem_rdata is sampled at the end of each beat. Split beats deposit rdata[7:0] into accumulator bits [8k+7:8k].
  - ACCESS → RESP after beat N-1. Memory outputs return to 0 on leaving ACCESS.
- ERR → RESP after 1 cycle, with o_rsp_err = 1 and no memory activity.
- RESP: o_rsp_valid = 1; o_rsp_rdata and o_rsp_err are stable. RESP → IDLE on i_rsp_ready. A new request is never accepted in the same cycle as a response handshake.
- Extension: LB / LH sign-extend bit 7 / bit 15; LBU / LHU zero-extend; LW passes through.
- Latency from accept to o_rsp_valid is N+1 cycles; 2 for an error.
- Byte addresses wrap inside ADDR_W. addr + k never crosses 2^ADDR_W, because the last legal word is checked by the range rule on addr + size - 1; a violation is an error.

Decomposition:
- lsu_pkg holds:
  - funct3 localparams.
  - Bmask constants BM_WORD, BM_HALF, BM_BYTE, BM_NONE.
  - state_t enum.
  - A beats_f(funct3, addr) function.
- One combinational sub-module, lsu_load_ext: inputs are funct3 and the raw 32-bit assembled data; output is the extended result.

Test Plan:
- Reset low for 2 cycles during ACCESS → state IDLE, o_mem_wren = 0, o_rsp_valid = 0, o_req_ready = 1.
- SW 0xDEADBEEF @0x010, then LW @0x010 → one wren pulse with bmask 1111; load returns 0xDEADBEEF, err = 0, latency 2.
- SB 0x80 @0x013, then LB @0x013 and LBU @0x013 → 0xFFFFFF80 and 0x00000080 respectively.
- SH 0x8001 @0x006, then LH @0x006 and LHU @0x006 → 0xFFFF8001 and 0x00008001 respectively.
- SW 0x11223344 @0x00D (split) → 4 wren pulses at addresses 0x00D..0x010 with bytes 44, 33, 22, 11. LW @0x00D → 0x11223344, latency 5.
- LW @0x800, LW @0x7FE, and funct3 = 011 → o_rsp_err = 1, rdata = 0, no wren. With SPLIT_MISALIGNED = 0, LH @0x001 → err. Hold i_rsp_ready = 0 for 3 cycles → o_rsp_valid held and o_req_ready = 0 throughout.
